// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the packet-router control slice:
//   state_t     - 4-bit controller state encoding
//   addr_width  - destination field width for a given port count, minimum 1
// -----------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [3:0] {
    ST_DA   = 4'd0,  // decode address (idle, waiting for a header)
    ST_LFD  = 4'd1,  // load first data (header byte)
    ST_LD   = 4'd2,  // load payload data
    ST_WTE  = 4'd3,  // wait till the selected FIFO is empty
    ST_CPE  = 4'd4,  // check parity error
    ST_LP   = 4'd5,  // load parity byte
    ST_FFS  = 4'd6,  // FIFO full, stalled
    ST_LAF  = 4'd7,  // load after full
    ST_DROP = 4'd8   // discard the current packet
  } state_t;

  function automatic int addr_width(input int num_ports);
    return ($clog2(num_ports) > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// -----------------------------------------------------------------------------
// router_wait_timer
// Bounded wait counter for the wait-till-empty state.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear the count (packet header accepted)
//   en       : count one waiting cycle
//   expire   : high during the last permitted waiting cycle (count == WAIT_MAX-1)
// WAIT_MAX = 0 removes the counter entirely; expire is then never asserted.
// -----------------------------------------------------------------------------
module router_wait_timer #(
  parameter int WAIT_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  generate
    if (WAIT_MAX == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, load, en};
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

      logic [CW-1:0] cnt;

      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of process ordering.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= '0;
        end else if (en && !expire) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expire = (cnt == CW'(WAIT_MAX - 1));
    end
  endgenerate

endmodule

// File: rtl/router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// router_ctrl_fsm
// Control FSM of an N-output packet router. Decodes the header destination,
// sequences header/payload/parity writes into the chosen FIFO, stalls around a
// full FIFO, drops packets with an invalid address or a wait-till-empty timeout,
// and counts dropped packets (saturating).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pkt_valid       byte stream valid (falls with the parity byte)
//   din             destination field of the header byte
//   fifo_full       full flag of the selected FIFO
//   fifo_empty      per-FIFO empty flags
//   soft_rst        per-FIFO soft reset (read timeout)
//   parity_done     parity byte registered
//   low_pkt_valid   pkt_valid fell while stalled on a full FIFO
//   wr_en_reg       FIFO write enable
//   detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
//   drop_pkt        state strobes
//   busy            stall request to the source
//   dest_sel        one-hot latched destination
//   drop_cnt        saturating dropped-packet count
// -----------------------------------------------------------------------------
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  parameter  int WAIT_MAX  = 64,
  parameter  int CNT_W     = 8,
  localparam int ADDR_W    = addr_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    din,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 wr_en_reg,
  output logic                 detect_addr,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 drop_pkt,
  output logic [CNT_W-1:0]     drop_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] dest;
  logic              dest_vld;   // dest holds a real port, not an invalid address
  logic              addr_bad;
  logic              hdr_accept;
  logic              drop_done;
  logic              wait_expire;

  assign addr_bad   = (int'(din) >= NUM_PORTS);
  assign hdr_accept = (state == ST_DA) && pkt_valid;
  assign drop_done  = (state == ST_DROP) && !pkt_valid;

  router_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (hdr_accept),
    .en     (state == ST_WTE),
    .expire (wait_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_DA;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_DA: begin
        if (pkt_valid) begin
          if (addr_bad)             state_nxt = ST_DROP;
          else if (fifo_empty[din]) state_nxt = ST_LFD;
          else                      state_nxt = ST_WTE;
        end
      end
      ST_LFD: state_nxt = ST_LD;
      ST_LD: begin
        if (fifo_full)       state_nxt = ST_FFS;
        else if (!pkt_valid) state_nxt = ST_LP;
      end
      ST_FFS: if (!fifo_full) state_nxt = ST_LAF;
      ST_LAF: begin
        if (parity_done)        state_nxt = ST_DA;
        else if (low_pkt_valid) state_nxt = ST_LP;
        else                    state_nxt = ST_LD;
      end
      ST_LP:  state_nxt = ST_CPE;
      ST_CPE: state_nxt = fifo_full ? ST_FFS : ST_DA;
      // An empty FIFO wins over a timeout expiring in the same cycle.
      ST_WTE: begin
        if (fifo_empty[dest]) state_nxt = ST_LFD;
        else if (wait_expire) state_nxt = ST_DROP;
      end
      ST_DROP: if (!pkt_valid) state_nxt = ST_DA;
      default: state_nxt = ST_DA;
    endcase

    // Read-side soft reset abandons the packet; DA and DROP hold no FIFO context.
    if (state != ST_DA && state != ST_DROP && soft_rst[dest]) state_nxt = ST_DA;
  end

  always_comb begin
    detect_addr = (state == ST_DA);
    lfd_state   = (state == ST_LFD);
    ld_state    = (state == ST_LD);
    laf_state   = (state == ST_LAF);
    full_state  = (state == ST_FFS);
    rst_int_reg = (state == ST_CPE);
    drop_pkt    = (state == ST_DROP);
    wr_en_reg   = (state == ST_LD) || (state == ST_LP) || (state == ST_LAF);
    busy        = (state == ST_LFD) || (state == ST_WTE) || (state == ST_CPE) ||
                  (state == ST_LP)  || (state == ST_FFS) || (state == ST_LAF);
    dest_sel    = '0;
    if (dest_vld && state != ST_DROP) dest_sel[dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest     <= '0;
      dest_vld <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (hdr_accept) begin
        dest     <= din;
        dest_vld <= !addr_bad;
      end
      if (drop_done && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl_fsm
// Directed bench for router_ctrl_fsm with NUM_PORTS=3, WAIT_MAX=4, CNT_W=2.
// The controller state is reconstructed from the Moore strobes.
// -----------------------------------------------------------------------------
module tb_router_ctrl_fsm;

  localparam logic [3:0] S_DA = 4'd0, S_LFD = 4'd1, S_LD = 4'd2, S_WTE = 4'd3,
                         S_CPE = 4'd4, S_LP = 4'd5, S_FFS = 4'd6, S_LAF = 4'd7,
                         S_DROP = 4'd8, S_BAD = 4'hF;

  logic       clk = 1'b0;
  logic       rst, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] din;
  logic [2:0] fifo_empty, soft_rst;
  logic       wr_en_reg, detect_addr, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy, drop_pkt;
  logic [2:0] dest_sel;
  logic [1:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  router_ctrl_fsm #(
    .NUM_PORTS (3),
    .WAIT_MAX  (4),
    .CNT_W     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .din           (din),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_rst      (soft_rst),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .wr_en_reg     (wr_en_reg),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy),
    .dest_sel      (dest_sel),
    .drop_pkt      (drop_pkt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes -> state code; more than one strobe at once decodes as S_BAD.
  function automatic logic [3:0] obs_state();
    if ($countones({detect_addr, lfd_state, ld_state, laf_state,
                    full_state, rst_int_reg, drop_pkt}) > 1) return S_BAD;
    if (drop_pkt)          return S_DROP;
    if (detect_addr)       return S_DA;
    if (lfd_state)         return S_LFD;
    if (ld_state)          return S_LD;
    if (laf_state)         return S_LAF;
    if (full_state)        return S_FFS;
    if (rst_int_reg)       return S_CPE;
    if (busy && wr_en_reg) return S_LP;
    if (busy)              return S_WTE;
    return S_BAD;
  endfunction

  function automatic logic exp_wr(input logic [3:0] s);
    return (s == S_LD) || (s == S_LP) || (s == S_LAF);
  endfunction

  function automatic logic exp_busy(input logic [3:0] s);
    return (s == S_LFD) || (s == S_WTE) || (s == S_CPE) ||
           (s == S_LP)  || (s == S_FFS) || (s == S_LAF);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
         busy, wr_en_reg, drop_pkt} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_strobes: got %b want %b", {detect_addr, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, busy, wr_en_reg, drop_pkt}, 9'b1_0000_0000);
    end
    total++;
    if ({dest_sel, drop_cnt} !== 5'b0) begin
      bad++;
      $display("FAIL reset_dest_cnt: got dest_sel=%b drop_cnt=%0d want 000/0", dest_sel, drop_cnt);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs_state() !== S_DA || dest_sel !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got state=%0d dest_sel=%b want 0/000", obs_state(), dest_sel);
    end
  endtask

  task automatic test_normal();
    logic       pv_s [6] = '{1, 1, 1, 0, 0, 0};
    logic [3:0] st_s [6] = '{S_LFD, S_LD, S_LD, S_LP, S_CPE, S_DA};
    din = 2'd1; fifo_empty = 3'b010;
    for (int i = 0; i < 6; i++) begin
      pkt_valid = pv_s[i];
      tick();
      total++;
      if (obs_state() !== st_s[i] || wr_en_reg !== exp_wr(st_s[i]) || busy !== exp_busy(st_s[i])) begin
        bad++;
        $display("FAIL normal[%0d]: got state=%0d wr=%b busy=%b want %0d/%b/%b", i,
                 obs_state(), wr_en_reg, busy, st_s[i], exp_wr(st_s[i]), exp_busy(st_s[i]));
      end
      if (i < 5) begin
        total++;
        if (dest_sel !== 3'b010) begin
          bad++;
          $display("FAIL normal_dest_sel[%0d]: got %b want 010", i, dest_sel);
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    logic       pv_s [4] = '{1, 1, 1, 0};
    logic [3:0] st_s [4] = '{S_DROP, S_DROP, S_DROP, S_DA};
    din = 2'd3; fifo_empty = 3'b111;
    for (int i = 0; i < 4; i++) begin
      pkt_valid = pv_s[i];
      tick();
      total++;
      if (obs_state() !== st_s[i] || wr_en_reg !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bad_addr[%0d]: got state=%0d wr=%b busy=%b want %0d/0/0", i,
                 obs_state(), wr_en_reg, busy, st_s[i]);
      end
      if (i < 3) begin
        total++;
        if (dest_sel !== 3'b000 || drop_cnt !== 2'd0) begin
          bad++;
          $display("FAIL bad_addr_hold[%0d]: got dest_sel=%b cnt=%0d want 000/0", i, dest_sel, drop_cnt);
        end
      end
    end
    total++;
    if (drop_cnt !== 2'd1) begin
      bad++;
      $display("FAIL bad_addr_cnt: got %0d want 1", drop_cnt);
    end
  endtask

  task automatic test_timeout_drop();
    logic       pv_s [6] = '{1, 1, 1, 1, 1, 0};
    logic [3:0] st_s [6] = '{S_WTE, S_WTE, S_WTE, S_WTE, S_DROP, S_DA};
    din = 2'd0; fifo_empty = 3'b000;
    for (int i = 0; i < 6; i++) begin
      pkt_valid = pv_s[i];
      tick();
      total++;
      if (obs_state() !== st_s[i] || wr_en_reg !== exp_wr(st_s[i])) begin
        bad++;
        $display("FAIL timeout_drop[%0d]: got state=%0d wr=%b want %0d/%b", i,
                 obs_state(), wr_en_reg, st_s[i], exp_wr(st_s[i]));
      end
    end
    total++;
    if (drop_cnt !== 2'd2) begin
      bad++;
      $display("FAIL timeout_drop_cnt: got %0d want 2", drop_cnt);
    end
  endtask

  // empty_at: step index at which fifo_empty[0] rises before the edge.
  task automatic test_timeout_rescue(input int empty_at, input string tag);
    logic [3:0] exp;
    din = 2'd0; fifo_empty = 3'b000;
    for (int i = 0; i < empty_at + 5; i++) begin
      pkt_valid  = (i <= empty_at + 1);
      fifo_empty = (i >= empty_at) ? 3'b001 : 3'b000;
      tick();
      if (i < empty_at)       exp = S_WTE;
      else if (i == empty_at) exp = S_LFD;
      else                    exp = (i == empty_at + 1) ? S_LD : (i == empty_at + 2) ? S_LP :
                                    (i == empty_at + 3) ? S_CPE : S_DA;
      total++;
      if (obs_state() !== exp || busy !== exp_busy(exp)) begin
        bad++;
        $display("FAIL %s[%0d]: got state=%0d busy=%b want %0d/%b", tag, i,
                 obs_state(), busy, exp, exp_busy(exp));
      end
    end
    total++;
    if (drop_cnt !== 2'd2) begin
      bad++;
      $display("FAIL %s_cnt: got %0d want 2", tag, drop_cnt);
    end
  endtask

  task automatic test_full_stall();
    logic       pv_s  [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic       ful_s [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    logic       lpv_s [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [3:0] st_s  [9] = '{S_LFD, S_LD, S_FFS, S_FFS, S_FFS, S_LAF, S_LP, S_CPE, S_DA};
    din = 2'd0; fifo_empty = 3'b001; parity_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pkt_valid = pv_s[i]; fifo_full = ful_s[i]; low_pkt_valid = lpv_s[i];
      tick();
      total++;
      if (obs_state() !== st_s[i] || wr_en_reg !== exp_wr(st_s[i]) || busy !== exp_busy(st_s[i])) begin
        bad++;
        $display("FAIL full_stall[%0d]: got state=%0d wr=%b busy=%b want %0d/%b/%b", i,
                 obs_state(), wr_en_reg, busy, st_s[i], exp_wr(st_s[i]), exp_busy(st_s[i]));
      end
    end
    low_pkt_valid = 1'b0;
  endtask

  task automatic test_soft_rst();
    logic [2:0] sr_s [4] = '{3'b000, 3'b000, 3'b001, 3'b100};
    logic [3:0] st_s [4] = '{S_LFD, S_LD, S_LD, S_DA};
    din = 2'd2; fifo_empty = 3'b100;
    for (int i = 0; i < 4; i++) begin
      pkt_valid = 1'b1; soft_rst = sr_s[i];
      tick();
      total++;
      if (obs_state() !== st_s[i]) begin
        bad++;
        $display("FAIL soft_rst[%0d]: got state=%0d want %0d", i, obs_state(), st_s[i]);
      end
    end
    pkt_valid = 1'b0; soft_rst = 3'b000;
    total++;
    if (drop_cnt !== 2'd2) begin
      bad++;
      $display("FAIL soft_rst_cnt: got %0d want 2", drop_cnt);
    end
  endtask

  task automatic test_rst_in_ffs();
    din = 2'd0; fifo_empty = 3'b001; pkt_valid = 1'b1;
    tick();
    tick();
    fifo_full = 1'b1;
    tick();
    total++;
    if (obs_state() !== S_FFS) begin
      bad++;
      $display("FAIL rst_ffs_setup: got state=%0d want %0d", obs_state(), S_FFS);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
         busy, wr_en_reg, drop_pkt, dest_sel, drop_cnt} !== 14'b1_0000_0000_000_00) begin
      bad++;
      $display("FAIL rst_ffs_outputs: got %b want %b", {detect_addr, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, busy, wr_en_reg, drop_pkt, dest_sel,
               drop_cnt}, 14'b1_0000_0000_000_00);
    end
    rst = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    logic [1:0] exp;
    din = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      pkt_valid = 1'b1;
      tick();
      total++;
      if (drop_pkt !== 1'b1) begin
        bad++;
        $display("FAIL saturate_drop[%0d]: got drop_pkt=%b want 1", k, drop_pkt);
      end
      pkt_valid = 1'b0;
      tick();
      exp = (k > 3) ? 2'd3 : 2'(k);
      total++;
      if (drop_cnt !== exp || obs_state() !== S_DA) begin
        bad++;
        $display("FAIL saturate_cnt[%0d]: got cnt=%0d state=%0d want %0d/0", k,
                 drop_cnt, obs_state(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; din = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b000; soft_rst = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    test_reset();
    test_normal();
    test_bad_addr();
    test_timeout_drop();
    test_timeout_rescue(2, "timeout_rescue");
    test_timeout_rescue(4, "timeout_race");
    test_full_stall();
    test_soft_rst();
    test_rst_in_ffs();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Parametrised packet-router control FSM for an N-output router. It decodes the destination from the header byte, sequences the header, payload and parity writes into the selected output FIFO, and stalls around a full FIFO. Beyond the fixed 3-port controller it adds three behaviours: an invalid-address drop path, a bounded wait-till-empty timeout that also drops the packet, and a saturating dropped-packet counter. It sits between the input register/parity block and the per-port FIFO bank.

## Interface
- NUM_PORTS, 3, number of output channels (2..16); ADDR_W = max(1, clog2(NUM_PORTS)) is a derived localparam
- WAIT_MAX, 64, maximum number of cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout
- CNT_W, 8, width of the drop counter

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  packet byte stream valid; falls together with the parity byte
- din  in  ADDR_W  destination field of the header byte
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- soft_rst  in  NUM_PORTS  per-FIFO soft reset (read timeout)
- parity_done  in  1  parity byte has been registered
- low_pkt_valid  in  1  pkt_valid fell while FIFO_FULL_STATE was active
- wr_en_reg  out  1  write enable toward the FIFO bank
- detect_addr, lfd_state, ld_state, laf_state, full_state  out  1 each  state strobes
- rst_int_reg  out  1  check-parity strobe
- busy  out  1  stall the source
- dest_sel  out  NUM_PORTS  one-hot latched destination
- drop_pkt  out  1  current packet is being discarded
- drop_cnt  out  CNT_W  saturating count of dropped packets

## Operation
- States (4-bit encoding): DA=0, LFD=1, LD=2, WTE=3, CPE=4, LP=5, FFS=6, LAF=7, DROP=8.
- DA: on pkt_valid, latch dest = din. If din >= NUM_PORTS, go to DROP. Else if fifo_empty[din] is set, go to LFD. Else go to WTE and clear the wait counter. Without pkt_valid, stay in DA.
- LFD: go to LD unconditionally.
- LD: if fifo_full, go to FFS. Else if !pkt_valid, go to LP. Else stay.
- FFS: stay while fifo_full. Otherwise go to LAF.
- LAF: if parity_done, go to DA. Else if low_pkt_valid, go to LP. Else go to LD.
- LP: go to CPE.
- CPE: if fifo_full, go to FFS. Else go to DA.
- WTE:
  - if fifo_empty[dest], go to LFD;
  - else if WAIT_MAX != 0 and the wait counter equals WAIT_MAX-1, go to DROP;
  - else increment the wait counter and stay.
- DROP: stay while pkt_valid. On the first cycle with !pkt_valid (the parity byte is consumed), go to DA and increment drop_cnt, saturating at 2^CNT_W-1.
- Soft reset: in any state except DA and DROP, soft_rst[dest] forces the next state to DA. It does not count as a drop.
- Priority: rst > soft_rst > normal transition.
- Output decode (Moore, from the state register):
  - detect_addr=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE, drop_pkt=DROP;
  - wr_en_reg = LD | LP | LAF;
  - busy = LFD | WTE | CPE | LP | FFS | LAF. busy is 0 in DA, LD and DROP, so the source keeps streaming into the sink.
- dest_sel = one-hot of the latched dest. It is all-zero in DA before the first latch and while in DROP.

## Timing
- Reset values: state=DA, detect_addr=1, every other strobe=0, busy=0, wr_en_reg=0, dest=0, dest_sel=0, wait counter=0, drop_cnt=0.
- Outputs are combinational from the registered state: zero added latency, one cycle per transition.
- The header byte (pkt_valid=1 in DA) is followed by LFD on the next cycle when the FIFO is empty. A 1-byte payload plus parity gives DA, LFD, LD, LP, CPE, DA.
- Timeout: WTE is entered at cycle t and exits to DROP at t+WAIT_MAX.
- fifo_empty[dest] and timeout expiry in the same cycle: go to LFD.
- Reset mid-packet returns to DA on the next edge. drop_cnt clears only on rst.

## Structure
- Package router_pkg holds the state typedef/encodings and the clog2-based ADDR_W helper. NUM_PORTS is not defined there.
- One sub-module, router_wait_timer: a load/enable/expire counter, WAIT_MAX-parametrised, with the WAIT_MAX=0 bypass.

## Test plan
- NUM_PORTS=3, header din=1, fifo_empty=3'b010, 2 payload bytes then pkt_valid=0 -> states DA,LFD,LD,LD,LP,CPE,DA; wr_en_reg high in LD/LP; dest_sel=3'b010.
- NUM_PORTS=3, din=3 -> DROP while pkt_valid; return to DA after pkt_valid falls; drop_cnt 0 -> 1; wr_en_reg never asserted.
- WAIT_MAX=4, fifo_empty[0]=0 held -> exactly 4 cycles in WTE, then DROP. Repeat with fifo_empty[0] rising on cycle 2 -> LFD, no drop.
- fifo_full asserted in LD for 3 cycles -> FFS for 3 cycles then LAF. Then parity_done=0, low_pkt_valid=1 -> LP,CPE,DA.
- soft_rst[dest] pulsed in LD -> DA next cycle, drop_cnt unchanged. rst asserted in FFS -> DA and all outputs at their reset values.
- CNT_W=2, 5 invalid-address packets -> drop_cnt saturates at 3.
